// File: rtl/vga_color_sequencer.sv
// vga_color_sequencer: drives the 4-bit CGA colour index in MANUAL, AUTO or BARS mode.
// Optional build macro SEQ_SKIP_BLACK_EN keeps MANUAL/AUTO stepping off index 0.
module vga_color_sequencer #(
  parameter int FRAMES_PER_STEP = 30,
  parameter int BAR_WIDTH       = 40
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Next,
  input  logic        i_Prev,
  input  logic        i_Mode,
  input  logic        i_VSync,
  input  logic [11:0] i_X,
  output logic [3:0]  o_Color,
  output logic [1:0]  o_Mode,
  output logic        o_Frame_Strobe
);

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_AUTO   = 2'd1,
    MODE_BARS   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

`ifdef SEQ_SKIP_BLACK_EN
  localparam bit SKIP_BLACK = 1'b1;
`else
  localparam bit SKIP_BLACK = 1'b0;
`endif

  localparam logic [7:0]  LAST_FRAME = 8'(FRAMES_PER_STEP - 1);
  localparam logic [11:0] LAST_COL   = 12'(BAR_WIDTH - 1);

  mode_t       r_mode, w_mode;
  logic        r_next_q, r_prev_q, r_mode_q, r_vsync_q;
  logic [3:0]  r_index, w_index;
  logic [7:0]  r_frame_cnt, w_frame_cnt;
  logic [11:0] r_col, w_col;
  logic [3:0]  r_bar, w_bar;
  logic [3:0]  r_color, w_color;
  logic        r_strobe;

  logic w_next_evt, w_prev_evt, w_mode_evt, w_frame_evt;
  logic w_step_up, w_step_dn, w_manual, w_skip, w_auto_step;

  function automatic logic [3:0] step_up(input logic [3:0] idx, input logic skip);
    if (skip && idx == 4'd15) return 4'd1;
    return idx + 4'd1;
  endfunction

  function automatic logic [3:0] step_dn(input logic [3:0] idx, input logic skip);
    if (skip && idx <= 4'd1) return 4'd15;
    return idx - 4'd1;
  endfunction

  assign w_next_evt  = i_Next & ~r_next_q;
  assign w_prev_evt  = i_Prev & ~r_prev_q;
  assign w_mode_evt  = i_Mode & ~r_mode_q;
  assign w_frame_evt = ~i_VSync & r_vsync_q;

  // Mode FSM next state; the reserved encoding falls back to MANUAL
  always_comb begin
    w_mode = r_mode;
    case (r_mode)
      MODE_MANUAL: if (w_mode_evt) w_mode = MODE_AUTO;
      MODE_AUTO:   if (w_mode_evt) w_mode = MODE_BARS;
      MODE_BARS:   if (w_mode_evt) w_mode = MODE_MANUAL;
      default:     w_mode = MODE_MANUAL;
    endcase
  end

  // Index stepping and the AUTO frame counter; a manual step overrides an auto step
  always_comb begin
    w_step_up   = w_next_evt & ~w_prev_evt;
    w_step_dn   = w_prev_evt & ~w_next_evt;
    w_manual    = w_next_evt | w_prev_evt;
    w_skip      = SKIP_BLACK && (r_mode != MODE_BARS);
    w_auto_step = (r_mode == MODE_AUTO) && w_frame_evt && !w_manual &&
                  (r_frame_cnt == LAST_FRAME);

    w_index = r_index;
    if (w_step_up)        w_index = step_up(r_index, w_skip);
    else if (w_step_dn)   w_index = step_dn(r_index, w_skip);
    else if (w_auto_step) w_index = step_up(r_index, w_skip);

    w_frame_cnt = r_frame_cnt;
    if (w_mode != r_mode || w_manual)
      w_frame_cnt = 8'd0;
    else if (r_mode == MODE_AUTO && w_frame_evt)
      w_frame_cnt = (r_frame_cnt == LAST_FRAME) ? 8'd0 : r_frame_cnt + 8'd1;
  end

  // Column/bar tracking: bar for the column currently on i_X, from last column's state
  always_comb begin
    w_col = r_col;
    w_bar = r_bar;
    if (i_X == 12'd0) begin
      w_col = 12'd0;
      w_bar = 4'd0;
    end else if (r_col == LAST_COL) begin
      w_col = 12'd0;
      w_bar = r_bar + 4'd1;
    end else begin
      w_col = r_col + 12'd1;
    end

    w_color = (w_mode == MODE_BARS) ? w_index + w_bar : w_index;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_mode      <= MODE_MANUAL;
      r_next_q    <= 1'b0;
      r_prev_q    <= 1'b0;
      r_mode_q    <= 1'b0;
      r_vsync_q   <= 1'b1;
      r_index     <= 4'd0;
      r_frame_cnt <= 8'd0;
      r_col       <= 12'd0;
      r_bar       <= 4'd0;
      r_color     <= 4'd0;
      r_strobe    <= 1'b0;
    end else begin
      r_mode      <= w_mode;
      r_next_q    <= i_Next;
      r_prev_q    <= i_Prev;
      r_mode_q    <= i_Mode;
      r_vsync_q   <= i_VSync;
      r_index     <= w_index;
      r_frame_cnt <= w_frame_cnt;
      r_col       <= w_col;
      r_bar       <= w_bar;
      r_color     <= w_color;
      r_strobe    <= w_frame_evt;
    end
  end

  assign o_Color        = r_color;
  assign o_Mode         = r_mode;
  assign o_Frame_Strobe = r_strobe;

endmodule

// File: tb/tb_vga_color_sequencer.sv
// Bench for vga_color_sequencer: directed scenarios plus random stimulus against a cycle model.
module tb_vga_color_sequencer;

  localparam int FPS = 3;
  localparam int BW  = 40;

  logic        i_Clk = 1'b0;
  logic        i_Reset = 1'b0;
  logic        i_Next = 1'b0, i_Prev = 1'b0, i_Mode = 1'b0, i_VSync = 1'b1;
  logic [11:0] i_X = 12'd0;
  logic [3:0]  o_Color;
  logic [1:0]  o_Mode;
  logic        o_Frame_Strobe;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_idx, m_mode, m_cnt, m_color;
  bit m_strobe;
  bit m_pn, m_pp, m_pm, m_pv;

  vga_color_sequencer #(.FRAMES_PER_STEP(FPS), .BAR_WIDTH(BW)) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Next(i_Next), .i_Prev(i_Prev),
    .i_Mode(i_Mode), .i_VSync(i_VSync), .i_X(i_X), .o_Color(o_Color),
    .o_Mode(o_Mode), .o_Frame_Strobe(o_Frame_Strobe)
  );

  always #5 i_Clk = ~i_Clk;

  function automatic int m_up(int idx, int mode);
`ifdef SEQ_SKIP_BLACK_EN
    if (mode != 2) return (idx == 15) ? 1 : idx + 1;
`endif
    return (idx + 1) % 16;
  endfunction

  function automatic int m_dn(int idx, int mode);
`ifdef SEQ_SKIP_BLACK_EN
    if (mode != 2) return (idx <= 1) ? 15 : idx - 1;
`endif
    return (idx + 15) % 16;
  endfunction

  // Advance the model with the inputs present now, then clock the DUT and settle
  task automatic tick();
    bit ne, pe, me, fe, manual, auto_step;
    int new_mode;
    ne = i_Next && !m_pn;
    pe = i_Prev && !m_pp;
    me = i_Mode && !m_pm;
    fe = !i_VSync && m_pv;
    if (i_Reset) begin
      m_idx = 0; m_mode = 0; m_cnt = 0; m_color = 0; m_strobe = 0;
      m_pn = 0; m_pp = 0; m_pm = 0; m_pv = 1;
    end else begin
      new_mode  = me ? (m_mode + 1) % 3 : m_mode;
      manual    = ne || pe;
      auto_step = (m_mode == 1) && fe && !manual && (m_cnt == FPS - 1);
      if (ne && !pe)      m_idx = m_up(m_idx, m_mode);
      else if (pe && !ne) m_idx = m_dn(m_idx, m_mode);
      else if (auto_step) m_idx = m_up(m_idx, m_mode);
      if (me || manual)             m_cnt = 0;
      else if (m_mode == 1 && fe)   m_cnt = (m_cnt == FPS - 1) ? 0 : m_cnt + 1;
      m_mode   = new_mode;
      m_strobe = fe;
      m_color  = (m_mode == 2) ? (m_idx + (int'(i_X) / BW)) % 16 : m_idx;
      m_pn = i_Next; m_pp = i_Prev; m_pm = i_Mode; m_pv = i_VSync;
    end
    @(posedge i_Clk);
    #1;
  endtask

  task automatic test_reset();
    i_Reset = 1'b1; i_Next = 0; i_Prev = 0; i_Mode = 0; i_VSync = 1; i_X = 0;
    tick(); tick();
    i_Reset = 1'b0;
    tick();
    n_cmp++; if (o_Color !== 4'd0) begin n_bad++; $display("FAIL reset_color got %0d want 0", o_Color); end
    n_cmp++; if (o_Mode !== 2'd0) begin n_bad++; $display("FAIL reset_mode got %0d want 0", o_Mode); end
    n_cmp++; if (o_Frame_Strobe !== 1'b0) begin n_bad++; $display("FAIL reset_strobe got %0d want 0", o_Frame_Strobe); end
  endtask

  task automatic test_manual_step();
    int exp_seq[7];
    exp_seq = '{1, 2, 3, 2, 1, 0, 15};
    for (int k = 0; k < 7; k++) begin
      if (k < 3) i_Next = 1'b1; else i_Prev = 1'b1;
      tick();
      n_cmp++; if (o_Color !== 4'(exp_seq[k])) begin n_bad++; $display("FAIL manual_step[%0d] got %0d want %0d", k, o_Color, exp_seq[k]); end
      n_cmp++; if (o_Mode !== 2'd0) begin n_bad++; $display("FAIL manual_mode[%0d] got %0d want 0", k, o_Mode); end
      i_Next = 1'b0; i_Prev = 1'b0;
      tick();
      n_cmp++; if (o_Color !== 4'(exp_seq[k])) begin n_bad++; $display("FAIL manual_hold[%0d] got %0d want %0d", k, o_Color, exp_seq[k]); end
    end
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 8; k++) begin
      i_Next = 1'b1; tick();
      i_Next = 1'b0; tick();
    end
    n_cmp++; if (o_Color !== 4'd7) begin n_bad++; $display("FAIL simul_setup got %0d want 7", o_Color); end
    i_Next = 1'b1; i_Prev = 1'b1;
    tick();
    n_cmp++; if (o_Color !== 4'd7) begin n_bad++; $display("FAIL simul_both got %0d want 7", o_Color); end
    i_Next = 1'b0; i_Prev = 1'b0;
    tick();
    n_cmp++; if (o_Color !== 4'(m_color)) begin n_bad++; $display("FAIL simul_model got %0d want %0d", o_Color, m_color); end
  endtask

  task automatic test_auto();
    int strobes;
    int exp_col;
    strobes = 0;
    i_Reset = 1'b1; tick(); i_Reset = 1'b0;
    i_Mode = 1'b1; tick(); i_Mode = 1'b0; tick();
    n_cmp++; if (o_Mode !== 2'd1) begin n_bad++; $display("FAIL auto_mode got %0d want 1", o_Mode); end
    for (int f = 1; f <= 7; f++) begin
      i_VSync = 1'b0;
      tick();
      if (o_Frame_Strobe === 1'b1) strobes++;
      exp_col = f / 3;
      n_cmp++; if (o_Color !== 4'(exp_col)) begin n_bad++; $display("FAIL auto_color[f%0d] got %0d want %0d", f, o_Color, exp_col); end
      for (int c = 0; c < 4; c++) begin
        if (c == 1) i_VSync = 1'b1;
        tick();
        if (o_Frame_Strobe === 1'b1) strobes++;
      end
      n_cmp++; if (o_Color !== 4'(m_color)) begin n_bad++; $display("FAIL auto_model[f%0d] got %0d want %0d", f, o_Color, m_color); end
    end
    n_cmp++; if (strobes != 7) begin n_bad++; $display("FAIL auto_strobe_count got %0d want 7", strobes); end
  endtask

  task automatic test_auto_next_coincide();
    int exp_col[6];
    exp_col = '{0, 0, 1, 1, 1, 2};
    i_Reset = 1'b1; tick(); i_Reset = 1'b0;
    i_Mode = 1'b1; tick(); i_Mode = 1'b0; tick();
    for (int f = 1; f <= 6; f++) begin
      i_VSync = 1'b0;
      if (f == 3) i_Next = 1'b1;
      tick();
      n_cmp++; if (o_Color !== 4'(exp_col[f-1])) begin n_bad++; $display("FAIL coincide[f%0d] got %0d want %0d", f, o_Color, exp_col[f-1]); end
      i_Next = 1'b0;
      tick();
      i_VSync = 1'b1;
      tick(); tick();
    end
  endtask

  task automatic test_bars();
    int want;
    i_Reset = 1'b1; tick(); i_Reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_Next = 1'b1; tick(); i_Next = 1'b0; tick();
    end
    for (int k = 0; k < 2; k++) begin
      i_Mode = 1'b1; tick(); i_Mode = 1'b0; tick();
    end
    n_cmp++; if (o_Mode !== 2'd2) begin n_bad++; $display("FAIL bars_mode got %0d want 2", o_Mode); end
    for (int line = 0; line < 2; line++) begin
      for (int x = 0; x < 640; x++) begin
        i_X = 12'(x);
        tick();
        want = (2 + x / BW) % 16;
        if (x % 20 == 0 || x % BW == BW - 1 || x >= 600) begin
          n_cmp++;
          if (o_Color !== 4'(want)) begin n_bad++; $display("FAIL bars_x%0d got %0d want %0d", x, o_Color, want); end
        end
      end
    end
    i_X = 12'd0;
    i_Mode = 1'b1; tick(); i_Mode = 1'b0; tick();
    n_cmp++; if (o_Mode !== 2'd0) begin n_bad++; $display("FAIL bars_wrap_mode got %0d want 0", o_Mode); end
    n_cmp++; if (o_Color !== 4'd2) begin n_bad++; $display("FAIL bars_back_color got %0d want 2", o_Color); end
  endtask

  task automatic test_reset_mid();
    i_Next = 1'b1; tick(); i_Next = 1'b0; tick();
    i_Mode = 1'b1; tick(); i_Mode = 1'b0; tick();
    i_Reset = 1'b1; i_Next = 1'b1; i_Mode = 1'b1; i_VSync = 1'b0;
    tick();
    n_cmp++; if (o_Color !== 4'd0) begin n_bad++; $display("FAIL rstmid_color got %0d want 0", o_Color); end
    n_cmp++; if (o_Mode !== 2'd0) begin n_bad++; $display("FAIL rstmid_mode got %0d want 0", o_Mode); end
    n_cmp++; if (o_Frame_Strobe !== 1'b0) begin n_bad++; $display("FAIL rstmid_strobe got %0d want 0", o_Frame_Strobe); end
    i_Reset = 1'b0; i_Next = 1'b0; i_Mode = 1'b0; i_VSync = 1'b1;
    tick();
    n_cmp++; if (o_Color !== 4'd0) begin n_bad++; $display("FAIL rstmid_after got %0d want 0", o_Color); end
  endtask

  task automatic test_random();
    int x;
    x = 0;
    i_Reset = 1'b1; i_X = 12'd0; tick(); i_Reset = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      i_Next  = ($urandom_range(0, 5) == 0);
      i_Prev  = ($urandom_range(0, 6) == 0);
      i_Mode  = ($urandom_range(0, 40) == 0);
      i_VSync = ($urandom_range(0, 9) != 0);
      i_Reset = (x == 639) && ($urandom_range(0, 3) == 0);
      i_X     = 12'(x);
      tick();
      x = (x + 1) % 640;
      n_cmp++; if (o_Color !== 4'(m_color)) begin n_bad++; $display("FAIL rand_color c%0d got %0d want %0d", c, o_Color, m_color); end
      n_cmp++; if (o_Mode !== 2'(m_mode)) begin n_bad++; $display("FAIL rand_mode c%0d got %0d want %0d", c, o_Mode, m_mode); end
      n_cmp++; if (o_Frame_Strobe !== m_strobe) begin n_bad++; $display("FAIL rand_strobe c%0d got %0d want %0d", c, o_Frame_Strobe, m_strobe); end
    end
    i_Reset = 1'b0; i_Next = 0; i_Prev = 0; i_Mode = 0; i_VSync = 1; i_X = 0;
  endtask

  initial begin
    #2;
    test_reset();
    test_manual_step();
    test_simultaneous();
    test_auto();
    test_auto_next_coincide();
    test_bars();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
